clkdiv_ratio_ctrl: RTL

Runtime-programmable clock divider with a ratio-change controller. It generates `clk_out` at 50% duty (half-cycle resolution for odd ratios, built from rising- and falling-edge phases) and accepts new ratios over a valid/ready handshake. New ratios are applied only at period boundaries, so `clk_out` never glitches or produces a runt pulse. It sits between the register/control logic and any block clocked by a derived slow clock.

---
 rtl/clkdiv_ratio_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/clkdiv_ratio_ctrl.sv
// Runtime-programmable 50%-duty clock divider with a glitch-free ratio-change handshake.
// Odd-ratio support (falling-edge phase) is built only when CLKDIV_CTRL_ODD_EN is defined.
module clkdiv_ratio_ctrl #(
    parameter int W = 4,
`ifdef CLKDIV_CTRL_ODD_EN
    parameter int DEFAULT_DIV = 7
`else
    parameter int DEFAULT_DIV = 8
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    input  logic [W-1:0] req_ratio,
    output logic         req_ready,
    output logic         req_err,
    output logic         busy,
    output logic [W-1:0] ratio_act,
    output logic         clk_out
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PEND   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic [W-1:0] DEF_RATIO = W'(DEFAULT_DIV);
    localparam logic [W-1:0] DEF_CNT   = W'(DEFAULT_DIV - 1);
    localparam logic [W-1:0] ONE       = W'(1);
    localparam logic [W-1:0] TWO       = W'(2);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] ratio_q, ratio_d;
    logic [W-1:0] pend_q, pend_d;
    logic         ph_p_q, ph_p_d;
    logic         err_q, err_d;
    logic         at_end;
    logic         xfer;
    logic         req_legal;

    always_comb begin
        at_end = (cnt_q == (ratio_q - ONE));
        xfer   = req_valid && (state_q == ST_RUN);
`ifdef CLKDIV_CTRL_ODD_EN
        req_legal = (req_ratio >= TWO);
`else
        req_legal = (req_ratio >= TWO) && !req_ratio[0];
`endif
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ratio_d = ratio_q;
        err_d   = 1'b0;
        cnt_d   = at_end ? '0 : (cnt_q + ONE);

        case (state_q)
            ST_RUN: begin
                if (xfer) begin
                    if (req_legal) begin
                        pend_d  = req_ratio;
                        state_d = ST_PEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PEND: begin
                // Swap only on the last count of a period: clk_out is low there.
                if (at_end) begin
                    ratio_d = pend_q;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (at_end) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Phase uses the ratio in force after this edge so the new period starts high.
        ph_p_d = (cnt_d < (ratio_d >> 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= DEF_CNT;
            ratio_q <= DEF_RATIO;
            pend_q  <= DEF_RATIO;
            ph_p_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            pend_q  <= pend_d;
            ph_p_q  <= ph_p_d;
            err_q   <= err_d;
        end
    end

`ifdef CLKDIV_CTRL_ODD_EN
    logic ph_n_q, ph_n_d;

    assign ph_n_d = ph_p_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_n_q <= 1'b0;
        end else begin
            ph_n_q <= ph_n_d;
        end
    end

    // Odd ratios stretch the high phase by half a cycle via the falling-edge copy.
    assign clk_out = ratio_q[0] ? (ph_p_q | ph_n_q) : ph_p_q;
`else
    assign clk_out = ph_p_q;
`endif

    assign req_ready = (state_q == ST_RUN);
    assign busy      = (state_q != ST_RUN);
    assign req_err   = err_q;
    assign ratio_act = ratio_q;

endmodule
